// File: rtl/subpel_pkg.sv
// Shared constants and state encoding for the sub-pixel interpolation blocks.
package subpel_pkg;
   localparam int SP_PIX_W = 8;
   localparam int SP_COLS  = 15;
   localparam int SP_ROWS  = 15;
   localparam int SP_IDX_W = 4;
   localparam int SP_ROW_W = SP_COLS * SP_PIX_W;

   typedef enum logic {
      LOAD  = 1'b0,
      SERVE = 1'b1
   } srv_state_t;
endpackage

// File: rtl/row_store.sv
// ROWS x COLS byte register file: one pixel written per cycle at (row, col),
// one full packed row read per cycle into a registered output.
module row_store
   import subpel_pkg::*;
#(
   parameter int PIX_W = SP_PIX_W,
   parameter int COLS  = SP_COLS,
   parameter int ROWS  = SP_ROWS,
   parameter int IDX_W = SP_IDX_W
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IDX_W-1:0]        wr_row,
   input  logic [IDX_W-1:0]        wr_col,
   input  logic [PIX_W-1:0]        wr_data,
   input  logic                    rd_en,
   input  logic                    rd_clr,
   input  logic [IDX_W-1:0]        rd_row,
   output logic [COLS*PIX_W-1:0]   rd_data
);

   // Contents are never cleared; the server only reads after a full reload.
   logic [PIX_W-1:0] mem [ROWS][COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_lane
         // Byte-lane write: only the addressed pixel register loads.
         always_ff @(posedge clk) begin
            if (we && wr_row == IDX_W'(r) && wr_col == IDX_W'(c))
               mem[r][c] <= wr_data;
         end
      end
   end

   // Registered row read; clear forces a zero row (rejected request / reset).
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         for (int c = 0; c < COLS; c++)
            rd_data[c*PIX_W +: PIX_W] <= mem[rd_row][c];
      end
   end

endmodule

// File: rtl/ref_row_server.sv
// Reference-frame row server: loads a ROWS x COLS pixel block from a raster
// byte stream, then answers row-index requests with one packed row each.
module ref_row_server
   import subpel_pkg::*;
#(
   parameter int PIX_W = SP_PIX_W,
   parameter int COLS  = SP_COLS,
   parameter int ROWS  = SP_ROWS,
   parameter int IDX_W = SP_IDX_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PIX_W-1:0]        pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic                    loaded,
   input  logic                    release_blk,
   input  logic                    req_valid,
   input  logic [IDX_W-1:0]        req_row,
   output logic                    rsp_valid,
   output logic [COLS*PIX_W-1:0]   rsp_row,
   output logic                    rsp_err
);

   srv_state_t       state_q, state_d;
   logic [IDX_W-1:0] row_cnt, col_cnt;
   logic             pix_hs, last_px, drop, req_acc, req_ok;
   // vld_pipe[0]: request accepted this cycle; vld_pipe[1]: response strobe.
   logic [1:0]       vld_pipe;
   logic             err_q;

   assign pix_ready = (state_q == LOAD);
   assign loaded    = (state_q == SERVE);
   assign pix_hs    = pix_valid && pix_ready;
   assign last_px   = pix_hs && (row_cnt == IDX_W'(ROWS-1)) && (col_cnt == IDX_W'(COLS-1));
   // Release wins over a same-cycle request, which is then dropped.
   assign drop      = loaded && release_blk;
   assign req_acc   = req_valid && !drop;
   assign req_ok    = req_acc && loaded && (req_row < IDX_W'(ROWS));
   assign vld_pipe[0] = req_acc;

   // Next-state logic: LOAD until the last pixel lands, SERVE until released.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (last_px) state_d = SERVE;
         SERVE:   if (release_blk) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // State, raster counters and response strobe/error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         row_cnt     <= '0;
         col_cnt     <= '0;
         vld_pipe[1] <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         vld_pipe[1] <= vld_pipe[0];
         if (req_acc)
            err_q <= !req_ok;
         if (last_px || drop) begin
            row_cnt <= '0;
            col_cnt <= '0;
         end else if (pix_hs) begin
            if (col_cnt == IDX_W'(COLS-1)) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + IDX_W'(1);
            end else begin
               col_cnt <= col_cnt + IDX_W'(1);
            end
         end
      end
   end

   // Rejected requests and reset zero the read register so rsp_row is 0;
   // otherwise it only changes on a good request and holds between strobes.
   row_store #(
      .PIX_W (PIX_W),
      .COLS  (COLS),
      .ROWS  (ROWS),
      .IDX_W (IDX_W)
   ) u_store (
      .clk     (clk),
      .we      (pix_hs),
      .wr_row  (row_cnt),
      .wr_col  (col_cnt),
      .wr_data (pix_in),
      .rd_en   (req_ok),
      .rd_clr  (rst || (req_acc && !req_ok)),
      .rd_row  (req_row),
      .rd_data (rsp_row)
   );

   assign rsp_valid = vld_pipe[1];
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_ref_row_server.sv
// Self-checking bench for ref_row_server: directed table, corner sequences
// and randomized requests against a pixel-array reference model.
module tb_ref_row_server;
   localparam int PW = 8;
   localparam int C  = 15;
   localparam int R  = 15;
   localparam int IW = 4;
   localparam int RW = C * PW;

   logic          clk = 1'b0;
   logic          rst, pix_valid, release_blk, req_valid;
   logic [PW-1:0] pix_in;
   logic [IW-1:0] req_row;
   logic          pix_ready, loaded, rsp_valid, rsp_err;
   logic [RW-1:0] rsp_row;

   ref_row_server dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .loaded(loaded), .release_blk(release_blk),
      .req_valid(req_valid), .req_row(req_row), .rsp_valid(rsp_valid),
      .rsp_row(rsp_row), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [PW-1:0] model [R][C];

   typedef struct {
      logic [IW-1:0] row;
      logic          err;
      logic [RW-1:0] data;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] exp_row(input int r);
      logic [RW-1:0] v = '0;
      for (int c = 0; c < C; c++) v[c*PW +: PW] = model[r][c];
      return v;
   endfunction

   function automatic logic [PW-1:0] pix_val(input int mode, input int r, input int c);
      case (mode)
         0:       return PW'(16*r + c);
         1:       return PW'(255 - (16*r + c));
         default: return PW'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stream a full block; toggle=1 drops pix_valid every other cycle.
   task automatic load_blk(input int mode, input bit toggle);
      int n = 0;
      int cyc = 0;
      logic [PW-1:0] v;
      while (n < R*C && cyc < 2000) begin
         pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         v = pix_val(mode, n / C, n % C);
         pix_in = v;
         if (n == R*C-1 && pix_valid) chk("loaded_before_last", loaded, 0);
         if (pix_valid && pix_ready) begin
            model[n / C][n % C] = v;
            n++;
         end
         step();
         cyc++;
      end
      pix_valid = 1'b0;
      chk("load_count", n, R*C);
      chk("loaded_after_last", loaded, 1);
      chk("pix_ready_serve", pix_ready, 0);
   endtask

   task automatic req_chk(input string nm, input int row, input bit in_serve);
      logic e;
      e = !in_serve || row >= R;
      req_valid = 1'b1;
      req_row = IW'(row);
      step();
      req_valid = 1'b0;
      chk({nm, "_valid"}, rsp_valid, 1);
      chk({nm, "_err"}, rsp_err, e);
      chk({nm, "_row"}, rsp_row, e ? '0 : exp_row(row));
   endtask

   initial begin
      logic          rv;
      int            rr;
      logic          last_err;
      logic [RW-1:0] last_row;

      rst = 1'b1; pix_valid = 1'b0; release_blk = 1'b0; req_valid = 1'b0;
      pix_in = '0; req_row = '0;
      step(); step();
      chk("rst_pix_ready", pix_ready, 1);
      chk("rst_loaded", loaded, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_row", rsp_row, 0);
      rst = 1'b0;

      // Request while loading is rejected, then the error holds while idle.
      req_chk("load_req", 3, 1'b0);
      step();
      chk("idle_valid", rsp_valid, 0);
      chk("idle_err_hold", rsp_err, 1);

      // Toggled-valid load of 16r+c.
      load_blk(0, 1'b1);

      // Directed table, issued back to back.
      tbl[0] = '{4'd3,  1'b0, exp_row(3)};
      tbl[1] = '{4'd0,  1'b0, exp_row(0)};
      tbl[2] = '{4'd14, 1'b0, exp_row(14)};
      tbl[3] = '{4'd7,  1'b0, exp_row(7)};
      tbl[4] = '{4'd12, 1'b0, exp_row(12)};
      tbl[5] = '{4'd15, 1'b1, '0};
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_row = tbl[i].row;
         step();
         chk($sformatf("tbl%0d_valid", i), rsp_valid, 1);
         chk($sformatf("tbl%0d_err", i), rsp_err, tbl[i].err);
         chk($sformatf("tbl%0d_row", i), rsp_row, tbl[i].data);
         if (i == 0) begin
            chk("row3_lo", rsp_row[7:0], 8'h30);
            chk("row3_hi", rsp_row[119:112], 8'h3e);
         end
         if (i == 1) chk("row0_lo", rsp_row[7:0], 8'h00);
         if (i == 2) chk("row14_lo", rsp_row[7:0], 8'he0);
         if (i == 3) chk("row7_lo", rsp_row[7:0], 8'h70);
      end
      req_valid = 1'b0;
      step();
      chk("tbl_idle_valid", rsp_valid, 0);
      chk("tbl_idle_err", rsp_err, 1);
      chk("tbl_idle_row", rsp_row, 0);

      // pix_valid high in SERVE must not write.
      pix_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pix_in = PW'($urandom);
         step();
      end
      pix_valid = 1'b0;
      chk("serve_pix_ready", pix_ready, 0);
      req_chk("serve_nowrite", 3, 1'b1);

      // Randomized requests against the model, including hold behaviour.
      last_err = rsp_err;
      last_row = rsp_row;
      for (int i = 0; i < 150; i++) begin
         rv = ($urandom_range(0, 3) != 0);
         rr = $urandom_range(0, 15);
         req_valid = rv;
         req_row = IW'(rr);
         step();
         chk("rnd_valid", rsp_valid, rv);
         if (rv) begin
            last_err = (rr >= R);
            last_row = (rr >= R) ? '0 : exp_row(rr);
         end
         chk("rnd_err", rsp_err, last_err);
         chk("rnd_row", rsp_row, last_row);
      end
      req_valid = 1'b0;

      // Release with a same-cycle request: request dropped.
      req_valid = 1'b1; req_row = 4'd3; release_blk = 1'b1;
      step();
      req_valid = 1'b0; release_blk = 1'b0;
      chk("rel_no_rsp", rsp_valid, 0);
      chk("rel_loaded", loaded, 0);
      chk("rel_pix_ready", pix_ready, 1);
      load_blk(1, 1'b0);
      req_chk("reload_row0", 0, 1'b1);
      chk("reload_row0_lo", rsp_row[7:0], 8'hff);

      // Reset mid-load discards the partial block.
      release_blk = 1'b1;
      step();
      release_blk = 1'b0;
      for (int i = 0; i < 100; i++) begin
         pix_valid = 1'b1;
         pix_in = PW'($urandom);
         req_valid = (i == 99);
         req_row = 4'd2;
         step();
      end
      pix_valid = 1'b0; req_valid = 1'b0;
      chk("pre_rst_err", rsp_err, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_pix_ready", pix_ready, 1);
      chk("mid_rst_loaded", loaded, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_err", rsp_err, 0);
      chk("mid_rst_row", rsp_row, 0);
      load_blk(2, 1'b0);
      req_chk("after_rst_row6", 6, 1'b1);
      for (int r = 0; r < R; r++) req_chk($sformatf("after_rst_row%0d", r), r, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
